// File: rtl/time_ctrl.sv
// time_ctrl: 24-hour hh:mm:ss clock driven by a RANGE-cycle prescaler, with set-hour/set-minute modes.
// Optional macro HOURLY_CHIME_EN adds a chime output held high for RANGE*hour cycles after each hour rollover.
module time_ctrl #(
    parameter int unsigned     WIDTH = 32,
    parameter longint unsigned RANGE = 64'd100000000
) (
    input  logic       clk_src,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       tick,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] mode
`ifdef HOURLY_CHIME_EN
    ,
    output logic       chime
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    localparam logic [WIDTH-1:0] PRESC_LAST = WIDTH'(RANGE - 64'd1);
    localparam logic [WIDTH-1:0] PRESC_ONE  = WIDTH'(1);

    mode_t            mode_reg;
    mode_t            mode_next;
    logic [WIDTH-1:0] presc_reg;
    logic             tick_reg;
    logic [4:0]       hour_reg;
    logic [5:0]       min_reg;
    logic [5:0]       sec_reg;

    logic             tick_due;
    logic             sec_last;
    logic             min_last;
    logic             hour_last;
    logic [4:0]       hour_inc;
    logic [5:0]       min_inc;
    logic [5:0]       sec_inc;

    always_comb begin
        tick_due  = (mode_reg == RUN) && (presc_reg == PRESC_LAST);
        sec_last  = (sec_reg == 6'd59);
        min_last  = (min_reg == 6'd59);
        hour_last = (hour_reg == 5'd23);
        sec_inc   = sec_last  ? 6'd0 : sec_reg + 6'd1;
        min_inc   = min_last  ? 6'd0 : min_reg + 6'd1;
        hour_inc  = hour_last ? 5'd0 : hour_reg + 5'd1;
        case (mode_reg)
            RUN:      mode_next = SET_HOUR;
            SET_HOUR: mode_next = SET_MIN;
            default:  mode_next = RUN;
        endcase
    end

    always_ff @(posedge clk_src) begin
        if (reset) begin
            mode_reg  <= RUN;
            presc_reg <= '0;
            tick_reg  <= 1'b0;
            hour_reg  <= '0;
            min_reg   <= '0;
            sec_reg   <= '0;
        end else begin
            tick_reg <= tick_due;
            if (tick_due) begin
                presc_reg <= '0;
                sec_reg   <= sec_inc;
                if (sec_last) begin
                    min_reg <= min_inc;
                    if (min_last)
                        hour_reg <= hour_inc;
                end
            end else if (mode_reg == RUN) begin
                presc_reg <= presc_reg + PRESC_ONE;
            end

            // A mode change wins over inc_btn; a due tick still lands its time update.
            if (mode_btn) begin
                mode_reg  <= mode_next;
                presc_reg <= '0;
                if (mode_reg == SET_MIN)
                    sec_reg <= '0;
            end else if (inc_btn) begin
                if (mode_reg == SET_HOUR)
                    hour_reg <= hour_inc;
                else if (mode_reg == SET_MIN)
                    min_reg <= min_inc;
            end
        end
    end

    assign tick = tick_reg;
    assign hour = hour_reg;
    assign min  = min_reg;
    assign sec  = sec_reg;
    assign mode = mode_reg;

`ifdef HOURLY_CHIME_EN
    localparam int unsigned   CW       = WIDTH + 5;
    localparam logic [CW-1:0] RANGE_CW = CW'(RANGE);

    logic [CW-1:0] chime_left_reg;
    logic [CW-1:0] chime_load;
    logic          chime_reg;
    logic          hour_carry;

    assign hour_carry = tick_due && sec_last && min_last;
    // Remaining high cycles after the load cycle itself.
    assign chime_load = RANGE_CW * CW'(hour_inc) - CW'(1);

    always_ff @(posedge clk_src) begin
        if (reset || mode_btn || (inc_btn && (mode_reg != RUN))) begin
            chime_reg      <= 1'b0;
            chime_left_reg <= '0;
        end else if (hour_carry) begin
            chime_reg      <= (hour_inc != 5'd0);
            chime_left_reg <= (hour_inc != 5'd0) ? chime_load : '0;
        end else if (chime_reg) begin
            if (chime_left_reg == '0)
                chime_reg <= 1'b0;
            else
                chime_left_reg <= chime_left_reg - CW'(1);
        end
    end

    assign chime = chime_reg;
`endif

endmodule

// File: tb/tb_time_ctrl.sv
// Bench for time_ctrl (RANGE=4): time-of-day model in seconds, per-cycle compare plus literal checkpoints.
`timescale 1ns/1ps
module tb_time_ctrl;

    localparam int RANGE = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       tick;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
`ifdef HOURLY_CHIME_EN
    logic       chime;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    time_ctrl #(.WIDTH(8), .RANGE(RANGE)) dut (
        .clk_src (clk),
        .reset   (reset),
        .mode_btn(mode_btn),
        .inc_btn (inc_btn),
        .tick    (tick),
        .hour    (hour),
        .min     (min),
        .sec     (sec),
        .mode    (mode)
`ifdef HOURLY_CHIME_EN
        ,
        .chime   (chime)
`endif
    );

    always #5 clk = ~clk;

    // Model: time as seconds-of-day, cycles spent in RUN since last tick or mode entry.
    bit m_valid = 0;
    int m_t = 0;
    int m_mode = 0;
    int m_cnt = 0;
    int m_tick = 0;
    int m_chime_left = 0;

    always @(posedge clk) begin
        int h, mi, s;
        if (reset) begin
            m_valid = 1; m_t = 0; m_mode = 0; m_cnt = 0; m_tick = 0; m_chime_left = 0;
        end else if (m_valid) begin
            m_tick = 0;
            if (m_chime_left > 0) m_chime_left--;
            if (m_mode == 0) begin
                m_cnt++;
                if (m_cnt == RANGE) begin
                    m_cnt = 0;
                    m_tick = 1;
                    m_t = (m_t + 1) % 86400;
                    if (m_t % 3600 == 0) m_chime_left = RANGE * (m_t / 3600);
                end
            end
            h = m_t / 3600; mi = (m_t / 60) % 60; s = m_t % 60;
            if (mode_btn) begin
                if (m_mode == 2) m_t = h * 3600 + mi * 60;
                m_mode = (m_mode + 1) % 3;
                m_cnt = 0;
                m_chime_left = 0;
            end else if (inc_btn && m_mode == 1) begin
                m_t = ((h + 1) % 24) * 3600 + mi * 60 + s;
                m_chime_left = 0;
            end else if (inc_btn && m_mode == 2) begin
                m_t = h * 3600 + ((mi + 1) % 60) * 60 + s;
                m_chime_left = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            tests_run++;
            if (tick !== 1'(m_tick) || hour !== 5'(m_t / 3600) || min !== 6'((m_t / 60) % 60) ||
                sec !== 6'(m_t % 60) || mode !== 2'(m_mode)) begin
                tests_failed++;
                $display("FAIL cycle_model t=%0t got tick=%0d %0d:%0d:%0d mode=%0d required tick=%0d %0d:%0d:%0d mode=%0d",
                         $time, tick, hour, min, sec, mode,
                         m_tick, m_t / 3600, (m_t / 60) % 60, m_t % 60, m_mode);
            end
`ifdef HOURLY_CHIME_EN
            tests_run++;
            if (chime !== (m_chime_left > 0)) begin
                tests_failed++;
                $display("FAIL cycle_chime t=%0t got %0d required %0d", $time, chime, m_chime_left > 0);
            end
`endif
        end
    end

    task automatic cyc(input logic mb, input logic ib);
        mode_btn = mb;
        inc_btn  = ib;
        @(negedge clk);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
    endtask

    task automatic check(input string name, input int actual, input int required);
        tests_run++;
        if (actual != required) begin
            tests_failed++;
            $display("FAIL %s got %0d required %0d", name, actual, required);
        end
        $display("[TB] %s: %0d", name, actual);
    endtask

    task automatic check_time(input string name, input int h, input int m, input int s, input int md);
        check({name, "_hour"}, int'(hour), h);
        check({name, "_min"},  int'(min),  m);
        check({name, "_sec"},  int'(sec),  s);
        check({name, "_mode"}, int'(mode), md);
    endtask

    initial begin
        int ticks;
        @(negedge clk);
        reset = 1'b1;
        cyc(1'b1, 1'b1);
        reset = 1'b0;
        check_time("reset", 0, 0, 0, 0);
        check("reset_tick", int'(tick), 0);

        // Free-running: ticks at cycles 4, 8, 12
        for (int c = 1; c <= 12; c++) begin
            run(1);
            check($sformatf("run_c%0d_tick", c), int'(tick), (c % 4 == 0) ? 1 : 0);
            check($sformatf("run_c%0d_sec", c), int'(sec), c / 4);
        end

        // Inc ignored in RUN
        incs(2);
        check_time("run_inc_ignored", 0, 0, 3, 0);

        // Set sequence with wraps
        cyc(1'b1, 1'b0);
        check("seq_mode1", int'(mode), 1);
        incs(25);
        check("seq_hour_wrap", int'(hour), 1);
        cyc(1'b1, 1'b1);
        check_time("seq_mode_and_inc", 1, 0, 3, 2);
        incs(61);
        check_time("seq_min_wrap", 1, 1, 3, 2);
        cyc(1'b1, 1'b0);
        check_time("seq_back_run", 1, 1, 0, 0);

        // Preload 23:59, run to 23:59:58, then day wrap
        cyc(1'b1, 1'b0);
        incs(22);
        cyc(1'b1, 1'b0);
        incs(58);
        cyc(1'b1, 1'b0);
        run(58 * RANGE);
        check_time("pre_2359_58", 23, 59, 58, 0);
        run(4);
        check_time("at_235959", 23, 59, 59, 0);
        run(3);
        check_time("before_wrap", 23, 59, 59, 0);
        run(1);
        check_time("day_wrap", 0, 0, 0, 0);
        check("day_wrap_tick", int'(tick), 1);

        // mode_btn coincident with the 3->4 tick
        run(15);
        check_time("pre_tick_03", 0, 0, 3, 0);
        cyc(1'b1, 1'b0);
        check_time("mode_on_tick", 0, 0, 4, 1);
        check("mode_on_tick_tick", int'(tick), 1);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            run(1);
            ticks += int'(tick);
        end
        check("set_no_ticks", ticks, 0);
        check("set_sec_hold", int'(sec), 4);
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);

        // 05:06:07 at prescaler 2, then reset with buttons pressed
        cyc(1'b1, 1'b0);
        incs(5);
        cyc(1'b1, 1'b0);
        incs(6);
        cyc(1'b1, 1'b0);
        run(7 * RANGE + 2);
        check_time("pre_reset", 5, 6, 7, 0);
        reset = 1'b1;
        cyc(1'b1, 1'b1);
        reset = 1'b0;
        check_time("mid_reset", 0, 0, 0, 0);
        run(3);
        check("post_reset_c3_tick", int'(tick), 0);
        run(1);
        check("post_reset_c4_tick", int'(tick), 1);
        check("post_reset_c4_sec", int'(sec), 1);

`ifdef HOURLY_CHIME_EN
        cyc(1'b1, 1'b0);
        incs(1);
        cyc(1'b1, 1'b0);
        incs(59);
        cyc(1'b1, 1'b0);
        run(60 * RANGE);
        check_time("chime_rollover", 2, 0, 0, 0);
        check("chime_start", int'(chime), 1);
        ticks = 1;
        for (int i = 0; i < 12; i++) begin
            run(1);
            ticks += int'(chime);
        end
        check("chime_len", ticks, 8);
        check("chime_end", int'(chime), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
